// File: rtl/tick_recv_pkg.sv
// Shared constants for the divided-clock path. The divider and the tick
// receiver both import this package so that they agree on the system clock
// rate, the divider tap positions and the default measurement widths.
package tick_recv_pkg;

  // System clock that every slow input is resampled into.
  localparam int SYS_CLK_HZ = 50_000_000;

  // Default period counter width; 2^27 cycles at 50 MHz fits comfortably.
  localparam int DEF_CNT_W = 28;

  // Default stall threshold: two seconds without a rising edge.
  localparam int DEF_TIMEOUT = 100_000_000;

  // Divider tap indices feeding this block (~1.5 Hz and ~0.75 Hz).
  localparam int DIV_TAP_FAST = 24;
  localparam int DIV_TAP_SLOW = 25;

  // Expected rising-to-rising period, in clk cycles, of a divider tap.
  function automatic longint tap_period_cycles(input int tap);
    return longint'(1) << (tap + 1);
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One receive channel: resamples an asynchronous slow level into clk,
// turns each rising edge into a one-cycle tick, measures the spacing
// between rising edges and flags an input that has stopped toggling.
module tick_chan
  import tick_recv_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             slow_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(TIMEOUT - 1);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic [CNT_W-1:0] period_next;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Rising edge of the synchronized level, and the period it closes,
  // rounded up to include the edge cycle and clamped to the counter range.
  always_comb begin
    rise        = s2 & ~s3;
    period_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  end

  // Elapsed-cycle counter: restarts on each edge, otherwise saturates.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Tick, period report and arming; the first edge only arms the channel.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tick       <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      armed      <= 1'b0;
    end else begin
      tick       <= rise;
      period_vld <= rise & armed;
      if (rise) begin
        armed <= 1'b1;
        if (armed) begin
          period <= period_next;
        end
      end
    end
  end

  // Stall flag: an edge always wins over the timeout threshold.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall <= 1'b0;
    end else if (rise) begin
      stall <= 1'b0;
    end else if (cnt >= STALL_AT) begin
      stall <= 1'b1;
    end
  end

endmodule

// File: rtl/tick_recv.sv
// Receiving end of the divided-clock path. Each slow square wave becomes a
// single-cycle enable in the clk domain plus a period measurement and a
// stall flag, so downstream logic never clocks off a divided signal.
module tick_recv
  import tick_recv_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [N_CH-1:0]       slow_in,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH*CNT_W-1:0] period,
  output logic [N_CH-1:0]       period_vld,
  output logic [N_CH-1:0]       stall
);

  // One independent channel per input; period results are packed so that
  // channel i sits at [i*CNT_W +: CNT_W].
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    tick_chan #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .clr_n      (clr_n),
      .slow_in    (slow_in[i]),
      .tick       (tick[i]),
      .period     (period[i*CNT_W +: CNT_W]),
      .period_vld (period_vld[i]),
      .stall      (stall[i])
    );
  end

endmodule
